occupancy_monitor: RTL and testbench

Parametrised multi-channel occupancy tracker: debounces N_CH raw occupancy status lines into stable per-channel occupied flags. Emits one-cycle arrive/depart event pulses and maintains a registered count of occupied channels with full/empty indications. Sits between the sensor input stage and the lot-level counting/display logic, replacing the single-channel, undebounced two-state tracker.

---
 rtl/occupancy_pkg.sv | 13 +
 rtl/occupancy_channel.sv | 106 ++++++++++
 rtl/occupancy_monitor.sv | 56 +++++
 tb/tb_occupancy_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/occupancy_pkg.sv
// Shared types for the occupancy monitor: per-channel state encoding and run-counter width.
package occupancy_pkg;

  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    VACANT    = 2'd0,
    ARMING    = 2'd1,
    OCCUPIED  = 2'd2,
    RELEASING = 2'd3
  } ch_state_e;

endpackage

// File: rtl/occupancy_channel.sv
// One debounced occupancy channel: run-length filter FSM plus registered arrive/depart pulses.
//
// state     | meaning
// VACANT    | stable vacant, flag = 0
// ARMING    | vacant, counting consecutive occupied samples
// OCCUPIED  | stable occupied, flag = 1
// RELEASING | occupied, counting consecutive vacant samples
module occupancy_channel
  import occupancy_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic status,
  input  logic ch_en,
  output logic flag,
  output logic flag_nxt,
  output logic arrive,
  output logic depart
);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE - 1);

  ch_state_e        state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= VACANT;
      run_cnt <= '0;
      arrive  <= 1'b0;
      depart  <= 1'b0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      arrive  <= flag_nxt & ~flag;
      depart  <= flag & ~flag_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    if (!ch_en) begin
      state_nxt = VACANT;
      run_nxt   = '0;
    end else begin
      case (state)
        VACANT: begin
          if (status) begin
            if (DEBOUNCE == 1) begin
              state_nxt = OCCUPIED;
            end else begin
              state_nxt = ARMING;
              run_nxt   = RUN_W'(1);
            end
          end
        end
        ARMING: begin
          if (!status) begin
            state_nxt = VACANT;
            run_nxt   = '0;
          end else if (run_cnt == RUN_LAST) begin
            state_nxt = OCCUPIED;
            run_nxt   = '0;
          end else begin
            run_nxt = run_cnt + RUN_W'(1);
          end
        end
        OCCUPIED: begin
          if (!status) begin
            if (DEBOUNCE == 1) begin
              state_nxt = VACANT;
            end else begin
              state_nxt = RELEASING;
              run_nxt   = RUN_W'(1);
            end
          end
        end
        RELEASING: begin
          if (status) begin
            state_nxt = OCCUPIED;
            run_nxt   = '0;
          end else if (run_cnt == RUN_LAST) begin
            state_nxt = VACANT;
            run_nxt   = '0;
          end else begin
            run_nxt = run_cnt + RUN_W'(1);
          end
        end
        default: begin
          state_nxt = VACANT;
          run_nxt   = '0;
        end
      endcase
    end
  end

  // flag_nxt lets the top register count on the same edge that flag changes.
  always_comb begin
    flag     = (state == OCCUPIED) || (state == RELEASING);
    flag_nxt = (state_nxt == OCCUPIED) || (state_nxt == RELEASING);
  end

endmodule

// File: rtl/occupancy_monitor.sv
// Multi-channel occupancy tracker: N_CH debounced channels plus a registered occupied-channel count.
module occupancy_monitor
  import occupancy_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DEBOUNCE = 3,
  localparam int CNT_W   = $clog2(N_CH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  status,
  input  logic [N_CH-1:0]  ch_en,
  output logic [N_CH-1:0]  flag,
  output logic [N_CH-1:0]  arrive,
  output logic [N_CH-1:0]  depart,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [N_CH-1:0]  flag_nxt;
  logic [CNT_W-1:0] pop_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    occupancy_channel #(.DEBOUNCE(DEBOUNCE)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .status   (status[i]),
      .ch_en    (ch_en[i]),
      .flag     (flag[i]),
      .flag_nxt (flag_nxt[i]),
      .arrive   (arrive[i]),
      .depart   (depart[i])
    );
  end

  // Counting next-state flags keeps count exactly aligned with flag, so it can never drift.
  always_comb begin
    pop_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop_nxt = pop_nxt + CNT_W'(flag_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= pop_nxt;
    end
  end

  assign full  = (count == CNT_W'(N_CH));
  assign empty = (count == '0);

endmodule

// File: tb/tb_occupancy_monitor.sv
// Randomized and directed check of occupancy_monitor against a run-length reference model.
module tb_occupancy_monitor;

  localparam int N  = 4;
  localparam int DB = 3;
  localparam int CW = $clog2(N + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  status, ch_en;
  wire  [N-1:0]  flag, arrive, depart;
  wire  [CW-1:0] count;
  wire           full, empty;

  logic     reset1, status1, ch_en1;
  wire      flag1, arrive1, depart1;
  wire      count1;
  wire      full1, empty1;

  occupancy_monitor #(.N_CH(N), .DEBOUNCE(DB)) u_dut (
    .clk(clk), .reset(reset), .status(status), .ch_en(ch_en),
    .flag(flag), .arrive(arrive), .depart(depart),
    .count(count), .full(full), .empty(empty)
  );

  occupancy_monitor #(.N_CH(1), .DEBOUNCE(1)) u_dut1 (
    .clk(clk), .reset(reset1), .status(status1), .ch_en(ch_en1),
    .flag(flag1), .arrive(arrive1), .depart(depart1),
    .count(count1), .full(full1), .empty(empty1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a channel flips once DEBOUNCE consecutive enabled samples disagree with its flag.
  bit           m_flag[N];
  int           m_run[N];
  logic [N-1:0] m_arr, m_dep;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_flag[i] = 1'b0;
      m_run[i]  = 0;
    end
    m_arr = '0;
    m_dep = '0;
  endtask

  task automatic model_step();
    bit prev;
    for (int i = 0; i < N; i++) begin
      prev = m_flag[i];
      if (!ch_en[i]) begin
        m_flag[i] = 1'b0;
        m_run[i]  = 0;
      end else if (status[i] != m_flag[i]) begin
        m_run[i]++;
        if (m_run[i] >= DB) begin
          m_flag[i] = ~m_flag[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_arr[i] = !prev && m_flag[i];
      m_dep[i] = prev && !m_flag[i];
    end
  endtask

  task automatic check_all();
    logic [N-1:0] ef;
    int c;
    c = 0;
    for (int i = 0; i < N; i++) begin
      ef[i] = m_flag[i];
      c += int'(m_flag[i]);
    end
    check("flag",   32'(flag),   32'(ef));
    check("arrive", 32'(arrive), 32'(m_arr));
    check("depart", 32'(depart), 32'(m_dep));
    check("count",  32'(count),  32'(c));
    check("full",   32'(full),   32'(c == N));
    check("empty",  32'(empty),  32'(c == 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic hold(input logic [N-1:0] s, input int n);
    status = s;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset   = 1'b0;
    status  = '1;
    ch_en   = '1;
    reset1  = 1'b0;
    status1 = 1'b0;
    ch_en1  = 1'b1;
    model_reset();

    // reset held with all channels reporting occupied
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset_empty", 32'(empty), 32'd1);
    reset = 1'b1;

    hold(4'b1111, 3);
    check("rel_flag",   32'(flag),   32'hF);
    check("rel_arrive", 32'(arrive), 32'hF);
    check("rel_full",   32'(full),   32'd1);
    step();

    hold(4'b0000, 3);
    // glitch on channel 0 shorter than the debounce window
    hold(4'b0001, 2);
    hold(4'b0000, 1);
    check("glitch_flag", 32'(flag[0]), 32'd0);
    hold(4'b0001, 3);
    check("arr0", 32'(arrive), 32'h1);

    hold(4'b0011, 3);
    hold(4'b0001, 1);
    hold(4'b0011, 1);
    check("dep_glitch", 32'(flag[1]), 32'd1);
    hold(4'b0001, 3);
    check("dep1", 32'(depart), 32'h2);

    // count 2 -> 3 with two arrivals and one departure on the same edge
    hold(4'b1010, 3);
    check("pre_sim_cnt", 32'(count), 32'd2);
    hold(4'b0111, 3);
    check("sim_arr", 32'(arrive), 32'h5);
    check("sim_dep", 32'(depart), 32'h8);
    check("sim_cnt", 32'(count),  32'd3);

    ch_en = 4'b1011;
    step();
    check("dis_dep", 32'(depart), 32'h4);
    for (int k = 0; k < 4; k++) begin
      status = status ^ 4'b0100;
      step();
    end
    status = 4'b0111;
    ch_en  = 4'b1111;
    hold(4'b0111, 3);

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) status[i] = ~status[i];
        ch_en[i] = ($urandom_range(15) != 0);
      end
      step();
      if (n % 150 == 149) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 reset = 1'b1;
      end
    end

    // single-channel, no-debounce instance
    status1 = 1'b0;
    @(posedge clk);
    #1 reset1 = 1'b1;
    status1 = 1'b1;
    @(posedge clk);
    #1;
    check("d1_flag",   32'(flag1),   32'd1);
    check("d1_arrive", 32'(arrive1), 32'd1);
    check("d1_count",  32'(count1),  32'd1);
    check("d1_full",   32'(full1),   32'd1);
    @(posedge clk);
    #1;
    check("d1_arrive_end", 32'(arrive1), 32'd0);
    status1 = 1'b0;
    @(posedge clk);
    #1;
    check("d1_flag_low", 32'(flag1),   32'd0);
    check("d1_depart",   32'(depart1), 32'd1);
    status1 = 1'b1;
    @(posedge clk);
    #1;
    check("d1_flag_hi", 32'(flag1), 32'd1);
    #2 reset1 = 1'b0;
    #1;
    check("d1_async_flag",  32'(flag1),  32'd0);
    check("d1_async_empty", 32'(empty1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
